// File: rtl/decoder_display_7_segment.sv
// Registered hex-to-7-segment decoder with lamp test, blanking and ripple-blanking.
// All outputs are registered; ACTIVE_LOW inverts the full 8-bit pattern for common-anode parts.
module decoder_display_7_segment #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       lamp_test,
    input  logic       rbi,
    input  logic       dp,
    input  logic [3:0] i,
    output logic [7:0] o,
    output logic       rbo
);

    localparam logic [7:0] OffPattern = {8{ACTIVE_LOW}};

    logic [6:0] seg;
    logic [7:0] pattern;
    logic [7:0] o_d;
    logic       rbo_d;

    // Active-high segment codes, bit order g..a.
    always_comb begin
        seg = 7'h00;
        case (i)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    always_comb begin
        pattern = {dp, seg};
        rbo_d   = 1'b0;
        if (lamp_test) begin
            pattern = 8'hFF;
        end else if (!en) begin
            pattern = 8'h00;
        end else if (rbi && (i == 4'h0)) begin
            // Suppressed leading zero: dp is blanked too, and the next digit is told to blank.
            pattern = 8'h00;
            rbo_d   = 1'b1;
        end
        o_d = ACTIVE_LOW ? ~pattern : pattern;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o   <= OffPattern;
            rbo <= 1'b0;
        end else begin
            o   <= o_d;
            rbo <= rbo_d;
        end
    end

endmodule

// File: tb/tb_decoder_display_7_segment.sv
// Bench for decoder_display_7_segment: directed steps then random stimulus,
// checking both polarities against a table-driven priority model.
module tb_decoder_display_7_segment;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, lamp_test, rbi, dp;
    logic [3:0] i;
    logic [7:0] o_hi, o_lo;
    logic       rbo_hi, rbo_lo;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16];

    always #5 clk = ~clk;

    decoder_display_7_segment #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .reset(reset), .en(en), .lamp_test(lamp_test), .rbi(rbi),
        .dp(dp), .i(i), .o(o_hi), .rbo(rbo_hi)
    );

    decoder_display_7_segment #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .reset(reset), .en(en), .lamp_test(lamp_test), .rbi(rbi),
        .dp(dp), .i(i), .o(o_lo), .rbo(rbo_lo)
    );

    task automatic check8(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check1(input string tag, input logic act, input logic exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    // Reference: active-high pattern from the priority rules.
    function automatic logic [7:0] model_o(input logic lt, input logic e, input logic rb,
                                           input logic d, input logic [3:0] v);
        if (lt) return 8'hFF;
        if (!e) return 8'h00;
        if (rb && v == 0) return 8'h00;
        return {d, seg_tab[v]};
    endfunction

    function automatic logic model_rbo(input logic lt, input logic e, input logic rb,
                                       input logic [3:0] v);
        return !lt && e && rb && (v == 0);
    endfunction

    task automatic drive(input logic lt, input logic e, input logic rb, input logic d,
                         input logic [3:0] v);
        lamp_test = lt; en = e; rbi = rb; dp = d; i = v;
    endtask

    // Apply inputs, take one edge, check both instances against the model.
    task automatic step_check(input string tag, input logic lt, input logic e, input logic rb,
                              input logic d, input logic [3:0] v);
        logic [7:0] exp;
        drive(lt, e, rb, d, v);
        @(posedge clk);
        #1;
        exp = model_o(lt, e, rb, d, v);
        check8({tag, "_o"}, o_hi, exp);
        check8({tag, "_olo"}, o_lo, ~exp);
        check1({tag, "_rbo"}, rbo_hi, model_rbo(lt, e, rb, v));
        check1({tag, "_rbolo"}, rbo_lo, model_rbo(lt, e, rb, v));
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h8);
        #12;
        check8("reset_o", o_hi, 8'h00);
        check8("reset_olo", o_lo, 8'hFF);
        check1("reset_rbo", rbo_hi, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check8("first_edge_o", o_hi, 8'h7F);
        check8("first_edge_olo", o_lo, 8'h80);

        for (int k = 0; k < 16; k++) begin
            step_check($sformatf("sweep_%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 4'(k));
        end

        step_check("dp5", 1'b0, 1'b1, 1'b0, 1'b1, 4'h5);
        check8("dp5_lit", o_hi, 8'hED);
        step_check("blank", 1'b0, 1'b0, 1'b0, 1'b1, 4'h5);
        step_check("lamp_en0", 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        check8("lamp_lit", o_hi, 8'hFF);
        step_check("rb_zero", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
        check1("rb_zero_lit", rbo_hi, 1'b1);
        step_check("rb_three", 1'b0, 1'b1, 1'b1, 1'b0, 4'h3);
        step_check("no_rb_zero", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step_check("lo_one", 1'b0, 1'b1, 1'b0, 1'b0, 4'h1);
        check8("lo_one_lit", o_lo, 8'hF9);

        // Mid-operation reset clears without an edge.
        step_check("pre_reset", 1'b0, 1'b1, 1'b0, 1'b1, 4'h8);
        #2;
        reset = 1'b1;
        #1;
        check8("mid_reset_o", o_hi, 8'h00);
        check8("mid_reset_olo", o_lo, 8'hFF);
        @(posedge clk);
        #1;
        check8("hold_reset_o", o_hi, 8'h00);
        reset = 1'b0;

        for (int k = 0; k < 300; k++) begin
            step_check("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
                       1'($urandom), 1'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
